// File: rtl/zero_det_scheduler.sv
// zero_det_scheduler: round-robin sharing of one serial zero detector; ZERO_DET_SCHED_FIRST_HIT_EN adds o_first_hit/o_has_hit.
module zero_det_scheduler #(
    parameter int N_REQ   = 4,
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 4,
    parameter int ID_W    = 2
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*FRAME_W-1:0] i_frame_data,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_busy,
    output logic                     o_det_reset,
    output logic                     o_det_x,
    input  logic                     i_det_y,
    output logic                     o_done,
    output logic [ID_W-1:0]          o_done_id,
    output logic [CNT_W-1:0]         o_hit_count
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
    ,
    output logic [$clog2(FRAME_W):0] o_first_hit,
    output logic                     o_has_hit
`endif
);
    localparam int BIT_W = $clog2(FRAME_W) + 1;

    if (2**CNT_W <= FRAME_W || 2**ID_W < N_REQ || N_REQ < 2 || N_REQ > 8) begin : g_param_check
        $error("zero_det_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, REPORT} state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr, r_id, r_done_id;
    logic [N_REQ-1:0]   r_grant;
    logic [FRAME_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt, r_hit_count;
    logic [BIT_W-1:0]   r_bit;
    logic               r_done;
    logic               w_any;
    logic [ID_W-1:0]    w_win;
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
    logic [BIT_W-1:0]   r_fh, r_first_hit;
    logic               r_fh_seen, r_has_hit;
`endif

    // Scan downward so the nearest set index after the pointer overwrites the rest.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (i_req[(int'(r_ptr) + k) % N_REQ]) begin
                w_any = 1'b1;
                w_win = ID_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_ptr       <= ID_W'(N_REQ - 1);
            r_id        <= '0;
            r_grant     <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
            r_hit_count <= '0;
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
            r_fh        <= '0;
            r_fh_seen   <= 1'b0;
            r_first_hit <= '0;
            r_has_hit   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_state   <= FLUSH;
                    r_id      <= w_win;
                    r_grant   <= N_REQ'(1) << w_win;
                    r_shift   <= i_frame_data[int'(w_win)*FRAME_W +: FRAME_W];
                    r_cnt     <= '0;
                    r_bit     <= '0;
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
                    r_fh      <= '0;
                    r_fh_seen <= 1'b0;
`endif
                end
                FLUSH: r_state <= SHIFT;
                SHIFT: begin
                    r_cnt   <= r_cnt + CNT_W'(i_det_y);
                    r_shift <= r_shift << 1;
                    r_bit   <= r_bit + BIT_W'(1);
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
                    if (i_det_y && !r_fh_seen) begin
                        r_fh_seen <= 1'b1;
                        r_fh      <= r_bit;
                    end
`endif
                    if (r_bit == BIT_W'(FRAME_W - 1)) begin
                        r_state     <= REPORT;
                        r_done      <= 1'b1;
                        r_done_id   <= r_id;
                        r_hit_count <= r_cnt + CNT_W'(i_det_y);
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
                        r_has_hit   <= r_fh_seen | i_det_y;
                        r_first_hit <= r_fh_seen ? r_fh : (i_det_y ? r_bit : '0);
`endif
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                    r_ptr   <= r_id;
                    r_grant <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_busy      = r_state != IDLE;
    assign o_det_reset = i_reset & (r_state != FLUSH);
    assign o_det_x     = (r_state == SHIFT) & r_shift[FRAME_W-1];
    assign o_done      = r_done;
    assign o_done_id   = r_done_id;
    assign o_hit_count = r_hit_count;
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
    assign o_first_hit = r_first_hit;
    assign o_has_hit   = r_has_hit;
`endif
endmodule

// File: tb/tb_zero_det_scheduler.sv
// tb_zero_det_scheduler: randomized self-checking bench with a behavioural arbiter/frame model and a 1-then-0 zero detector.
module tb_zero_det_scheduler;
    localparam int N = 4;
    localparam int FW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*FW-1:0] frame_data = '0;
    logic [N-1:0]  grant;
    logic          busy, det_reset, det_x, det_y, done;
    logic [1:0]    done_id;
    logic [3:0]    hit_count;
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
    logic [3:0]    first_hit;
    logic          has_hit;
`endif

    int total = 0;
    int bad = 0;
    int m_ptr = N - 1;

    always #5 clock = ~clock;

    // External detector: y=1 when a 0 follows a 1, history cleared by its active-low reset.
    logic det_seen;
    always_ff @(posedge clock or negedge det_reset)
        if (!det_reset) det_seen <= 1'b0;
        else det_seen <= det_x;
    assign det_y = det_seen & ~det_x;

    zero_det_scheduler dut (
        .i_clock(clock), .i_reset(reset), .i_req(req), .i_frame_data(frame_data),
        .o_grant(grant), .o_busy(busy), .o_det_reset(det_reset), .o_det_x(det_x),
        .i_det_y(det_y), .o_done(done), .o_done_id(done_id), .o_hit_count(hit_count)
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
        , .o_first_hit(first_hit), .o_has_hit(has_hit)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] rq);
        for (int k = 1; k <= N; k++)
            if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic void ref_frame(input logic [FW-1:0] f, output int hits, output int first);
        hits = 0;
        first = -1;
        for (int i = 1; i < FW; i++)
            if (f[FW-i] && !f[FW-1-i]) begin
                hits++;
                if (first < 0) first = i;
            end
    endfunction

    task automatic do_txn(input logic [N-1:0] rq, input logic [N*FW-1:0] fd, input bit drop);
        int w, hits, first;
        logic [FW-1:0] f;
        @(negedge clock);
        req = rq;
        frame_data = fd;
        w = rr_pick(rq);
        f = fd[w*FW +: FW];
        ref_frame(f, hits, first);
        @(posedge clock); #1;
        check("grant_e0", grant, 32'(1 << w));
        check("busy", busy, 1);
        check("flush_det_reset", det_reset, 0);
        check("flush_det_x", det_x, 0);
        if (drop) begin
            req = '0;
            frame_data = {$urandom, $urandom} ;
        end
        for (int c = 1; c <= FW; c++) begin
            @(posedge clock); #1;
            check("grant_held", grant, 32'(1 << w));
            check("no_done", done, 0);
            check("shift_det_x", det_x, f[FW-c]);
            check("shift_det_reset", det_reset, 1);
        end
        @(posedge clock); #1;
        check("done", done, 1);
        check("done_id", done_id, w);
        check("hit_count", hit_count, hits);
        check("grant_report", grant, 32'(1 << w));
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
        check("has_hit", has_hit, first >= 0);
        check("first_hit", first_hit, first >= 0 ? first : 0);
`endif
        m_ptr = w;
        @(posedge clock); #1;
        check("gap_done", done, 0);
        check("gap_grant", grant, 0);
        check("gap_busy", busy, 0);
        check("hold_count", hit_count, hits);
        check("hold_id", done_id, w);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_done_id"}, done_id, 0);
        check({tag, "_hit_count"}, hit_count, 0);
        check({tag, "_det_x"}, det_x, 0);
        check({tag, "_det_reset"}, det_reset, 0);
`ifdef ZERO_DET_SCHED_FIRST_HIT_EN
        check({tag, "_first_hit"}, first_hit, 0);
        check({tag, "_has_hit"}, has_hit, 0);
`endif
    endtask

    initial begin
        logic [N-1:0] rq;
        logic [N*FW-1:0] fd;
        repeat (2) @(posedge clock);
        #1 check_reset_state("reset");
        @(negedge clock) reset = 1'b1;

        for (int i = 0; i < 5; i++) do_txn(4'b1111, {$urandom, $urandom} , 1'b0);
        do_txn(4'b0001, 32'h000000AA, 1'b0);
        do_txn(4'b0100, 32'h00F00000, 1'b0);
        do_txn(4'b0010, 32'h00000000, 1'b0);
        do_txn(4'b0001, 32'h00000007, 1'b0);
        do_txn(4'b0001, 32'h00000040, 1'b0);
        do_txn(4'b1000, 32'h80FF0101, 1'b1);
        for (int i = 0; i < 20; i++) begin
            rq = 4'($urandom_range(1, 15));
            fd = {$urandom, $urandom} ;
            do_txn(rq, fd, 1'($urandom_range(0, 1)));
        end

        @(negedge clock);
        req = 4'b1000;
        frame_data = 32'hFF000000;
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        req = '0;
        #1 check_reset_state("midreset");
        m_ptr = N - 1;
        @(posedge clock); #1;
        check("midreset_no_done", done, 0);
        @(negedge clock) reset = 1'b1;
        do_txn(4'b1001, 32'h0000_00AA, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zero_det_scheduler.md
Name: zero_det_scheduler

Overview:
- Shares one serial Mealy zero-detector instance among N_REQ requesters, round-robin.
- Per grant: latches the winner's FRAME_W-bit frame and flushes the detector via its active-low reset. It then shifts the frame MSB-first into the detector's x_in, counts detector y_out hits, and reports the count back.
- Sits between requester logic and the single detector instance; the detector is an external, unmodified instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_W, 8, bits per frame shifted into detector.
- CNT_W, 4, hit counter width; must satisfy 2**CNT_W > FRAME_W.
- ID_W, 2, requester index width; must satisfy 2**ID_W >= N_REQ.

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- req, input, N_REQ, per-requester request level.
- frame_data, input, N_REQ*FRAME_W, requester i frame at bits [i*FRAME_W +: FRAME_W].
- grant, output, N_REQ, one-hot grant, held for the whole transaction.
- busy, output, 1, high in any state other than IDLE.
- det_reset, output, 1, active-low reset driven to detector.
- det_x, output, 1, serial bit driven to detector x_in.
- det_y, input, 1, detector y_out (combinational Mealy output).
- done, output, 1, one-cycle pulse when result valid.
- done_id, output, ID_W, index of requester that finished.
- hit_count, output, CNT_W, number of det_y=1 cycles in the frame.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; grant=0, busy=0, done=0, done_id=0, hit_count=0, det_x=0.
  - det_reset=0 while reset is low.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, FLUSH, SHIFT, REPORT.
- IDLE, any req bit set:
  - Pick the first set req index searching upward from pointer+1, wrapping.
  - Latch that requester's frame into the shift register; set grant one-hot; clear the counter.
  - Next state FLUSH.
- FLUSH, exactly 1 cycle:
  - det_reset=0 (detector returns to its start state); det_x=0.
  - Next state SHIFT.
- SHIFT, exactly FRAME_W cycles:
  - det_x = shift register MSB; det_reset=1.
  - On each edge: counter += det_y (sampled in the same cycle det_x is presented); shift left by 1.
  - Leave after bit index FRAME_W-1 is presented.
- REPORT, 1 cycle:
  - done=1; done_id = granted index; hit_count = final count.
  - Pointer <= granted index; grant cleared at the end of this cycle.
  - Next state IDLE.
- hit_count and done_id hold their values until the next REPORT.
- Latency: req sampled at edge E0 -> grant visible after E0 -> done high in the cycle after edge E0+FRAME_W+1, i.e. FRAME_W+2 edges after sampling.
- Gap: at least one IDLE cycle between back-to-back transactions.
- req is sampled only in IDLE.
  - Deassertion during a transaction is ignored; the frame still completes and is reported.
  - frame_data changes after latch are ignored.
- Simultaneous requests: strict round-robin. A requester holding req continuously is re-served only after all other pending requesters.
- Counter never wraps under legal parameters; a CNT_W that violates the rule is a parameter error (elaboration check).
- det_reset = reset AND (state != FLUSH). This is combinational, so reset propagates to the detector immediately.
- Reset mid-transaction: abort with no done pulse; pointer returns to N_REQ-1.

Optional Feature:
- Macro: ZERO_DET_SCHED_FIRST_HIT_EN.
- Defined:
  - Adds output first_hit (ID_W+... width clog2(FRAME_W)+1) = bit index (0 = MSB) of the first det_y=1 in the frame.
  - Adds output has_hit.
  - Both are valid with done, reset to 0, and hold like hit_count.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Single req[0]=1, frame 8'b10101010, real detector instance -> grant=4'b0001 for 10 cycles; done with done_id=0, hit_count=4.
- req[2]=1, frame 8'b11110000 -> hit_count=1. With FIRST_HIT_EN: first_hit=4, has_hit=1.
- req[1]=1, frame 8'h00 -> hit_count=0; has_hit=0 when enabled.
- req=4'b1111 held continuously -> done_id sequence 0,1,2,3,0; no grant overlap; grant is always one-hot or zero.
- Detector pre-dirtied by a previous frame ending in 1s (8'b00000111), then next frame 8'b01000000 -> FLUSH clears history; second hit_count=1, not 2.
- Assert reset=0 for 1 cycle during SHIFT of req[3] -> det_reset low immediately, no done pulse, all outputs at reset values. After release with req=4'b1001, requester 0 is granted first.
